// File: rtl/subtractor_32bit_serial.sv
// Multi-cycle N-bit subtractor (minuend - subtrahend) that processes W bits
// per clock through a registered borrow chain. Operands are captured on a
// start request, consumed LSB chunk first, and the result plus borrow,
// signed-overflow and zero flags are published with a one-cycle done pulse.
module subtractor_32bit_serial #(
  parameter int N = 32,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] minuend,
  input  logic [N-1:0] subtrahend,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] difference,
  output logic         borrow_out,
  output logic         overflow,
  output logic         zero
);

  localparam int CHUNKS = N / W;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_a;          // remaining minuend bits, current chunk in [W-1:0]
  logic [N-1:0]     r_b;          // remaining subtrahend bits, current chunk in [W-1:0]
  logic [N-1:0]     r_work;       // partial result, filled from the top down
  logic             r_borrow;     // borrow carried between chunks
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;
  logic [N-1:0]     r_difference;
  logic             r_borrow_out;
  logic             r_overflow;
  logic             r_zero;

  logic [W-1:0]     w_diff_chunk;
  logic             w_bin;
  logic             w_chunk_bout;
  logic [N-1:0]     w_result;

  // Ripple the borrow through the current W-bit chunk.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    w_diff_chunk = '0;
    w_bin        = r_borrow;
    for (int i = 0; i < W; i++) begin
      w_diff_chunk[i] = r_a[i] ^ r_b[i] ^ w_bin;
      w_bin           = (~r_a[i] & r_b[i]) | (~r_a[i] & w_bin) | (r_b[i] & w_bin);
    end
    w_chunk_bout = w_bin;
    // New chunk enters at the top; after N/W shifts the result is aligned.
    w_result = (N'(w_diff_chunk) << (N - W)) | (r_work >> W);
  end

  // Control FSM and datapath registers; outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register, including the operand and working state, is cleared so no stale partial result survives a reset.
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_work       <= '0;
      r_borrow     <= 1'b0;
      r_count      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_difference <= '0;
      r_borrow_out <= 1'b0;
      r_overflow   <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= minuend;
            r_b      <= subtrahend;
            r_work   <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_a      <= r_a >> W;
          r_b      <= r_b >> W;
          r_work   <= w_result;
          r_borrow <= w_chunk_bout;
          if (r_count == LAST_CHUNK) begin
            // The current chunk holds the operand and result sign bits here.
            r_difference <= w_result;
            r_borrow_out <= w_chunk_bout;
            r_overflow   <= (r_a[W-1] != r_b[W-1]) && (w_diff_chunk[W-1] != r_a[W-1]);
            r_zero       <= (w_result == '0);
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_count      <= '0;
            r_state      <= S_IDLE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign difference = r_difference;
  assign borrow_out = r_borrow_out;
  assign overflow   = r_overflow;
  assign zero       = r_zero;

endmodule

// File: tb/tb_subtractor_32bit_serial.sv
// Self-checking bench for subtractor_32bit_serial: directed vector table,
// randomized operands against an arithmetic reference model, and handshake
// corner cases (back-to-back start, ignored start, asynchronous reset).
module tb_subtractor_32bit_serial;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] minuend;
  logic [31:0] subtrahend;
  logic        busy;
  logic        done;
  logic [31:0] difference;
  logic        borrow_out;
  logic        overflow;
  logic        zero;

  int n_checks = 0;
  int n_errors = 0;

  subtractor_32bit_serial #(.N(32), .W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        br;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 33-bit arithmetic and the signed-overflow rule.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] d, output logic br,
                                output logic ov, output logic z);
    logic [32:0] t;
    t  = {1'b0, a} - {1'b0, b};
    d  = t[31:0];
    br = t[32];
    ov = (a[31] != b[31]) && (d[31] != a[31]);
    z  = (d == 32'h0);
  endfunction

  // Called at a negedge: request, let the next edge accept, then scramble inputs.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    start      = 1'b1;
    minuend    = a;
    subtrahend = b;
    @(negedge clk);
    start      = 1'b0;
    minuend    = $urandom;
    subtrahend = $urandom;
  endtask

  // Called at the negedge after the accepting edge; returns when done is seen.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] d,
                              input logic br, input logic ov, input logic z);
    check({tag, ".difference"}, 64'(difference), 64'(d));
    check({tag, ".borrow_out"}, 64'(borrow_out), 64'(br));
    check({tag, ".overflow"},   64'(overflow),   64'(ov));
    check({tag, ".zero"},       64'(zero),       64'(z));
  endtask

  initial begin
    int lat;
    int bc;
    int dcount;
    logic [31:0] a, b, ed;
    logic ebr, eov, ez;

    vecs[0] = '{a: 32'd5678,       b: 32'd1000,       d: 32'h0000_1246, br: 1'b0, ov: 1'b0, z: 1'b0};
    vecs[1] = '{a: 32'd1000,       b: 32'd5678,       d: 32'hFFFF_EDBA, br: 1'b1, ov: 1'b0, z: 1'b0};
    vecs[2] = '{a: 32'h8000_0000,  b: 32'h0000_0001,  d: 32'h7FFF_FFFF, br: 1'b0, ov: 1'b1, z: 1'b0};
    vecs[3] = '{a: 32'h7FFF_FFFF,  b: 32'hFFFF_FFFF,  d: 32'h8000_0000, br: 1'b1, ov: 1'b1, z: 1'b0};
    vecs[4] = '{a: 32'hDEAD_BEEF,  b: 32'hDEAD_BEEF,  d: 32'h0000_0000, br: 1'b0, ov: 1'b0, z: 1'b1};

    rst = 1'b1; start = 1'b0; minuend = '0; subtrahend = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check_result("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vector table, with latency and busy-window checks.
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].a, vecs[i].b);
      wait_done(lat, bc);
      check($sformatf("vec%0d.latency", i), 64'(lat), 64'd8);
      check($sformatf("vec%0d.busy_cycles", i), 64'(bc), 64'd8);
      check_result($sformatf("vec%0d", i), vecs[i].d, vecs[i].br, vecs[i].ov, vecs[i].z);
      @(negedge clk);
      check($sformatf("vec%0d.done_drop", i), 64'(done), 64'd0);
      check_result($sformatf("vec%0d.hold", i), vecs[i].d, vecs[i].br, vecs[i].ov, vecs[i].z);
    end

    // Randomized operands against the reference model.
    for (int i = 0; i < 25; i++) begin
      a = $urandom;
      b = (i % 5 == 0) ? a : 32'($urandom);
      model(a, b, ed, ebr, eov, ez);
      issue(a, b);
      wait_done(lat, bc);
      check($sformatf("rand%0d.latency", i), 64'(lat), 64'd8);
      check_result($sformatf("rand%0d", i), ed, ebr, eov, ez);
      @(negedge clk);
    end

    // Zero result followed by a start held on the done cycle.
    issue(32'h1234_5678, 32'h1234_5678);
    wait_done(lat, bc);
    check("b2b.first_latency", 64'(lat), 64'd8);
    check_result("b2b.first", 32'h0, 1'b0, 1'b0, 1'b1);
    issue(32'h0, 32'h1);
    check("b2b.done_drop", 64'(done), 64'd0);
    check("b2b.busy_again", 64'(busy), 64'd1);
    check_result("b2b.hold_during_run", 32'h0, 1'b0, 1'b0, 1'b1);
    wait_done(lat, bc);
    check("b2b.second_latency", 64'(lat), 64'd8);
    check_result("b2b.second", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Start while busy is ignored; only one done pulse follows.
    issue(32'd100, 32'd300);
    @(negedge clk);
    start = 1'b1; minuend = 32'd9; subtrahend = 32'd2;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dcount++;
        if (dcount == 1) begin
          model(32'd100, 32'd300, ed, ebr, eov, ez);
          check_result("ignored_start", ed, ebr, eov, ez);
        end
      end
      @(negedge clk);
    end
    check("ignored_start.done_pulses", 64'(dcount), 64'd1);
    check("ignored_start.idle", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a run (after chunk 3, during chunk 4).
    issue(32'd50, 32'd80);
    repeat (4) @(negedge clk);
    check("midreset.busy_before", 64'(busy), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("midreset.busy", 64'(busy), 64'd0);
    check("midreset.done", 64'(done), 64'd0);
    check_result("midreset", 32'h0, 1'b0, 1'b0, 1'b0);
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("midreset.no_activity", 64'(dcount), 64'd0);
    issue(32'd7, 32'd3);
    wait_done(lat, bc);
    check("postreset.latency", 64'(lat), 64'd8);
    check_result("postreset", 32'd4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
